// File: rtl/pipe_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard / hazard controller.
// The defaults here also seed the parameter defaults of the scoreboard modules.
package pipe_pkg;

    localparam int NREGS_DEF   = 32;
    localparam int MAX_LAT_DEF = 15;
    localparam int DIV_LAT_DEF = 8;
    localparam int RAW         = $clog2(NREGS_DEF);
    localparam int LW          = $clog2(MAX_LAT_DEF + 1);

    typedef logic [LW-1:0]  lat_t;
    typedef logic [RAW-1:0] regidx_t;

    localparam lat_t LAT_ALU  = lat_t'(0);
    localparam lat_t LAT_LOAD = lat_t'(1);
    localparam lat_t LAT_DIV  = lat_t'(DIV_LAT_DEF);

endpackage

// File: rtl/pipe_scoreboard_if.sv
// Issue-side handshake and scoreboard status bundle between decode and the scoreboard.
interface pipe_scoreboard_if
    import pipe_pkg::*;
#(
    parameter int NREGS   = NREGS_DEF,
    parameter int MAX_LAT = MAX_LAT_DEF
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(MAX_LAT + 1);

    logic              iss_valid;
    logic [AW-1:0]     iss_rs1;
    logic              iss_rs1_use;
    logic [AW-1:0]     iss_rs2;
    logic              iss_rs2_use;
    logic [AW-1:0]     iss_rd;
    logic              iss_rd_wr;
    logic [CW-1:0]     iss_lat;
    logic              iss_div;
    logic              flush_e;
    logic              stall_d;
    logic [NREGS-1:0]  busy_mask;
    logic              div_busy;
    logic [31:0]       stall_cnt;

    modport master (
        output iss_valid, iss_rs1, iss_rs1_use, iss_rs2, iss_rs2_use,
               iss_rd, iss_rd_wr, iss_lat, iss_div, flush_e,
        input  stall_d, busy_mask, div_busy, stall_cnt
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs1_use, iss_rs2, iss_rs2_use,
               iss_rd, iss_rd_wr, iss_lat, iss_div, flush_e,
        output stall_d, busy_mask, div_busy, stall_cnt
    );

endinterface

// File: rtl/pipe_scoreboard_slot.sv
// One scoreboard entry: a saturating down-counter of cycles until the register's
// pending result is forwardable, with a registered nonzero flag.
module sb_slot
    import pipe_pkg::*;
#(
    parameter int CW = LW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [CW-1:0] load_val,
    input  logic          restore_en,
    input  logic [CW-1:0] restore_val,
    output logic [CW-1:0] cnt,
    output logic          busy
);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          busy_r;

    // Next count: a new issue beats a squash restore, which beats the plain countdown.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load_en) begin
            cnt_nxt_s = load_val;
        end else if (restore_en) begin
            cnt_nxt_s = restore_val;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_nxt_s = cnt_r - CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and busy flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            busy_r <= (cnt_nxt_s != {CW{1'b0}});
        end
    end

    assign cnt  = cnt_r;
    assign busy = busy_r;

endmodule

// File: rtl/pipe_scoreboard.sv
// Register scoreboard and decode hazard controller: per-register countdowns, RAW/WAW/divider
// stalls, squash of the last accepted instruction, and a saturating stall-cycle counter.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREGS     = NREGS_DEF,
    parameter int MAX_LAT   = MAX_LAT_DEF,
    parameter int DIV_LAT   = DIV_LAT_DEF,
    parameter int REG0_ZERO = 1
) (
    input  logic               clk,
    input  logic               reset,
    pipe_scoreboard_if.slave   sb
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(MAX_LAT + 1);

    logic [CW-1:0]    cnt_s [NREGS];
    logic [NREGS-1:0] busy_s;

    logic             raw_s;
    logic             waw_s;
    logic             divh_s;
    logic             stall_s;
    logic             accept_s;
    logic             flush_hit_s;
    logic [CW-1:0]    restore_val_s;
    logic [CW-1:0]    div_nxt_s;

    logic             last_valid_r;
    logic [AW-1:0]    last_rd_r;
    logic             last_wr_r;
    logic             last_div_r;
    logic [CW-1:0]    last_old_r;
    logic [CW-1:0]    div_cnt_r;
    logic             div_busy_r;
    logic [31:0]      stall_cnt_r;

    // Hazard detection and the accept/squash qualifiers for this cycle.
    always_comb begin
        raw_s    = (sb.iss_rs1_use && (cnt_s[sb.iss_rs1] != {CW{1'b0}})) ||
                   (sb.iss_rs2_use && (cnt_s[sb.iss_rs2] != {CW{1'b0}}));
        waw_s    = sb.iss_rd_wr && (cnt_s[sb.iss_rd] > sb.iss_lat);
        divh_s   = sb.iss_div && (div_cnt_r != {CW{1'b0}});
        stall_s  = sb.iss_valid && !sb.flush_e && (raw_s || waw_s || divh_s);
        accept_s = sb.iss_valid && !stall_s && !sb.flush_e;
        flush_hit_s = sb.flush_e && last_valid_r && last_wr_r;
        if (last_old_r != {CW{1'b0}}) begin
            restore_val_s = last_old_r - CW'(1);
        end else begin
            restore_val_s = {CW{1'b0}};
        end
    end

    // Register 0 stays tied to zero when hardwired, so it never raises RAW or WAW.
    for (genvar r = 0; r < NREGS; r++) begin : g_slot
        if ((REG0_ZERO != 0) && (r == 0)) begin : g_zero
            assign cnt_s[r]  = {CW{1'b0}};
            assign busy_s[r] = 1'b0;
        end else begin : g_live
            logic load_en_s;
            logic restore_en_s;
            assign load_en_s    = accept_s && sb.iss_rd_wr && (sb.iss_rd == AW'(r));
            assign restore_en_s = flush_hit_s && (last_rd_r == AW'(r));
            sb_slot #(.CW(CW)) u_slot (
                .clk         (clk),
                .reset       (reset),
                .load_en     (load_en_s),
                .load_val    (sb.iss_lat),
                .restore_en  (restore_en_s),
                .restore_val (restore_val_s),
                .cnt         (cnt_s[r]),
                .busy        (busy_s[r])
            );
        end
    end

    // Divider occupancy: countdown, cancelled by a squashed divide, reloaded by a new one.
    always_comb begin
        div_nxt_s = div_cnt_r;
        if (accept_s && sb.iss_div) begin
            div_nxt_s = CW'(DIV_LAT);
        end else if (flush_hit_s && last_div_r) begin
            div_nxt_s = {CW{1'b0}};
        end else if (div_cnt_r != {CW{1'b0}}) begin
            div_nxt_s = div_cnt_r - CW'(1);
        end else begin
            div_nxt_s = div_cnt_r;
        end
    end

    // Divider counter, last-issue record and stall statistics.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt_r    <= {CW{1'b0}};
            div_busy_r   <= 1'b0;
            last_valid_r <= 1'b0;
            last_rd_r    <= {AW{1'b0}};
            last_wr_r    <= 1'b0;
            last_div_r   <= 1'b0;
            last_old_r   <= {CW{1'b0}};
            stall_cnt_r  <= 32'd0;
        end else begin
            div_cnt_r  <= div_nxt_s;
            div_busy_r <= (div_nxt_s != {CW{1'b0}});
            if (accept_s) begin
                last_valid_r <= 1'b1;
                last_rd_r    <= sb.iss_rd;
                last_wr_r    <= sb.iss_rd_wr;
                last_div_r   <= sb.iss_div;
                last_old_r   <= cnt_s[sb.iss_rd];
            end else begin
                last_valid_r <= 1'b0;
            end
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign sb.stall_d   = stall_s;
    assign sb.busy_mask = busy_s;
    assign sb.div_busy  = div_busy_r;
    assign sb.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed-vector bench for pipe_scoreboard with hand-computed expectations.
module tb_pipe_scoreboard;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   st;
    int   hi;

    pipe_scoreboard_if #(.NREGS(32), .MAX_LAT(15)) sbif ();

    pipe_scoreboard #(.NREGS(32), .MAX_LAT(15), .DIV_LAT(8), .REG0_ZERO(1)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        sbif.iss_valid   = 1'b0;
        sbif.iss_rs1     = 5'd0;
        sbif.iss_rs1_use = 1'b0;
        sbif.iss_rs2     = 5'd0;
        sbif.iss_rs2_use = 1'b0;
        sbif.iss_rd      = 5'd0;
        sbif.iss_rd_wr   = 1'b0;
        sbif.iss_lat     = LAT_ALU;
        sbif.iss_div     = 1'b0;
        sbif.flush_e     = 1'b0;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wr, input lat_t lat, input logic dv);
        sbif.iss_valid   = 1'b1;
        sbif.iss_rs1     = rs1;
        sbif.iss_rs1_use = u1;
        sbif.iss_rs2     = rs2;
        sbif.iss_rs2_use = u2;
        sbif.iss_rd      = rd;
        sbif.iss_rd_wr   = wr;
        sbif.iss_lat     = lat;
        sbif.iss_div     = dv;
    endtask

    // Hold the driven instruction until accepted; returns the number of stall cycles seen.
    task automatic run_until_accept(input string tag, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sbif.stall_d) stalls++;
            else done = 1'b1;
            step();
        end
        check_vec({tag, "_accepted"}, 32'(done), 32'd1);
        clear_in();
    endtask

    task automatic idle_cycles(input int n);
        clear_in();
        repeat (n) step();
    endtask

    initial begin
        reset = 1'b0;
        clear_in();
        step();
        step();
        @(negedge clk);
        check_vec("rst_busy_mask", sbif.busy_mask, 32'h0);
        check_vec("rst_div_busy", 32'(sbif.div_busy), 32'd0);
        check_vec("rst_stall_cnt", sbif.stall_cnt, 32'd0);
        check_vec("rst_stall_d", 32'(sbif.stall_d), 32'd0);
        reset = 1'b1;
        step();

        // 1: load x5 then dependent add: one bubble
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, LAT_LOAD, 1'b0);
        run_until_accept("t1_load", st);
        check_vec("t1_load_stalls", 32'(st), 32'd0);
        drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, LAT_ALU, 1'b0);
        #1;
        check_vec("t1_busy_x5", sbif.busy_mask, 32'h0000_0020);
        run_until_accept("t1_add", st);
        check_vec("t1_add_stalls", 32'(st), 32'd1);
        check_vec("t1_stall_cnt", sbif.stall_cnt, 32'd1);

        // 2: ALU producer then consumer: no bubbles, x7 never busy
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, LAT_ALU, 1'b0);
        run_until_accept("t2_alu", st);
        check_vec("t2_alu_stalls", 32'(st), 32'd0);
        drive(5'd7, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1, LAT_ALU, 1'b0);
        #1;
        check_vec("t2_busy_mask", sbif.busy_mask, 32'h0);
        run_until_accept("t2_use", st);
        check_vec("t2_use_stalls", 32'(st), 32'd0);

        // 3: back-to-back divides, then a consumer of a divide result
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, LAT_DIV, 1'b1);
        run_until_accept("t3_div8", st);
        check_vec("t3_div8_stalls", 32'(st), 32'd0);
        check_vec("t3_div_busy", 32'(sbif.div_busy), 32'd1);
        check_vec("t3_busy_x8", sbif.busy_mask, 32'h0000_0100);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LAT_DIV, 1'b1);
        run_until_accept("t3_div9", st);
        check_vec("t3_divh_stalls", 32'(st), 32'd8);
        check_vec("t3_busy_x9", sbif.busy_mask, 32'h0000_0200);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sbif.div_busy) hi++;
            step();
        end
        check_vec("t3_div_busy_cycles", 32'(hi), 32'd8);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, LAT_DIV, 1'b1);
        run_until_accept("t3_div8b", st);
        drive(5'd8, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, LAT_ALU, 1'b0);
        run_until_accept("t3_use8", st);
        check_vec("t3_raw_stalls", 32'(st), 32'd8);
        check_vec("t3_stall_cnt", sbif.stall_cnt, 32'd17);

        // 4: flush after a load, with an unrelated divide in flight
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, LAT_DIV, 1'b1);
        run_until_accept("t4_div11", st);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, LAT_LOAD, 1'b0);
        run_until_accept("t4_load", st);
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, LAT_ALU, 1'b0);
        sbif.flush_e = 1'b1;
        @(negedge clk);
        check_vec("t4_flush_stall_d", 32'(sbif.stall_d), 32'd0);
        step();
        clear_in();
        @(negedge clk);
        check_vec("t4_busy_after_flush", sbif.busy_mask, 32'h0000_0800);
        check_vec("t4_div_busy_kept", 32'(sbif.div_busy), 32'd1);
        check_vec("t4_stall_cnt_kept", sbif.stall_cnt, 32'd17);
        step();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, lat_t'(3), 1'b0);
        run_until_accept("t4_lat3", st);
        sbif.flush_e = 1'b1;
        step();
        clear_in();
        @(negedge clk);
        check_vec("t4_restore_x5", sbif.busy_mask, 32'h0000_0800);
        idle_cycles(10);

        // 5: WAW against an in-flight divide result
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, LAT_DIV, 1'b1);
        run_until_accept("t5_div10", st);
        idle_cycles(3);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, LAT_ALU, 1'b0);
        run_until_accept("t5_alu10", st);
        check_vec("t5_waw_stalls", 32'(st), 32'd5);
        check_vec("t5_stall_cnt", sbif.stall_cnt, 32'd22);
        check_vec("t5_busy_mask", sbif.busy_mask, 32'h0);

        // 6: x0 traffic never stalls; reset mid-divide clears everything
        drive(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, LAT_DIV, 1'b0);
        run_until_accept("t6_wr_x0", st);
        drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, LAT_ALU, 1'b0);
        run_until_accept("t6_rd_x0", st);
        check_vec("t6_x0_stalls", 32'(st), 32'd0);
        check_vec("t6_x0_busy", sbif.busy_mask, 32'h0);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, LAT_DIV, 1'b1);
        run_until_accept("t6_div12", st);
        idle_cycles(2);
        check_vec("t6_pre_rst_div_busy", 32'(sbif.div_busy), 32'd1);
        reset = 1'b0;
        step();
        @(negedge clk);
        check_vec("t6_rst_busy_mask", sbif.busy_mask, 32'h0);
        check_vec("t6_rst_div_busy", 32'(sbif.div_busy), 32'd0);
        check_vec("t6_rst_stall_cnt", sbif.stall_cnt, 32'd0);
        reset = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
